uart_mem_loader: RTL

//  Serial boot/load initiator: parses framed bytes from the UART receiver, issues word writes to memory as bus

---
 rtl/uart_mem_loader_pkg.sv | 29 ++
 rtl/uart_mem_loader_timer.sv | 35 +++
 rtl/uart_mem_loader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_mem_loader_pkg.sv
// Shared state encoding, default frame constants and state classification helpers
// for the serial memory loader.
package uart_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_CHK   = 3'd5,
        ST_RESP  = 3'd6
    } state_t;

    localparam logic [7:0]  MAGIC_DEF   = 8'hA5;
    localparam logic [7:0]  ACK_DEF     = 8'h06;
    localparam logic [7:0]  NAK_DEF     = 8'h15;
    localparam logic [31:0] TIMEOUT_DEF = 32'd5500000;

    function automatic logic takes_byte(input state_t s);
        return s inside {ST_IDLE, ST_ADDR, ST_LEN, ST_DATA, ST_CHK};
    endfunction

    // States in which the host owes us the next byte of a frame.
    function automatic logic is_timed(input state_t s);
        return s inside {ST_ADDR, ST_LEN, ST_DATA, ST_CHK};
    endfunction

endpackage

// File: rtl/uart_mem_loader_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module uart_mem_loader_timer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd5500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 32'd1;
        end
    end

    // A clear in the same cycle (byte accepted) suppresses expiry.
    assign expired = en && !clr && (count_q == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Framed serial loader: parses MAGIC/ADDR/LEN/DATA/CHK frames from the UART
// receiver, writes each word to memory as it completes and replies ACK or NAK.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter logic [7:0]  MAGIC          = MAGIC_DEF,
    parameter logic [7:0]  ACK_BYTE       = ACK_DEF,
    parameter logic [7:0]  NAK_BYTE       = NAK_DEF,
    parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        rx_clear,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] rem_q, rem_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  chk_q, chk_d;
    logic        ack_q, ack_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rx_clear_q, rx_clear_d;
    logic        tx_start_q, tx_start_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        accept, timed, expired;

    // rx_clear_q blocks the stale rx_ready seen while the receiver is being cleared.
    assign accept = rx_ready && !rx_clear_q && takes_byte(state_q);
    assign timed  = is_timed(state_q);

    uart_mem_loader_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .clr    (accept || !timed),
        .en     (timed),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            chk_q      <= '0;
            ack_q      <= 1'b0;
            tx_data_q  <= '0;
            rx_clear_q <= 1'b0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            rx_clear_q <= rx_clear_d;
            tx_start_q <= tx_start_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        ack_d   = ack_q;
        if (accept && timed) begin
            chk_d = chk_q ^ rx_data;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept && rx_data == MAGIC) begin
                    state_d = ST_ADDR;
                    chk_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_ADDR: begin
                if (accept) begin
                    addr_d = {rx_data, addr_q[31:8]};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        addr_d[1:0] = 2'b00;
                        state_d     = ST_LEN;
                    end
                end
            end
            ST_LEN: begin
                if (accept) begin
                    rem_d = {rx_data, rem_q[15:8]};
                    if (idx_q[0]) begin
                        idx_d   = '0;
                        state_d = (rem_d == 16'd0) ? ST_CHK : ST_DATA;
                    end else begin
                        idx_d = 2'd1;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    wdata_d = {rx_data, wdata_q[31:8]};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    addr_d  = addr_q + 32'd4;
                    rem_d   = rem_q - 16'd1;
                    state_d = (rem_q == 16'd1) ? ST_CHK : ST_DATA;
                end
            end
            ST_CHK: begin
                if (accept) begin
                    ack_d   = (rx_data == chk_q);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (expired) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        rx_clear_d = accept;
        tx_start_d = (state_q == ST_RESP) && !tx_busy;
        tx_data_d  = tx_start_d ? (ack_q ? ACK_BYTE : NAK_BYTE) : tx_data_q;
        done_d     = tx_start_d && ack_q;
        err_d      = (tx_start_d && !ack_q) || expired;
    end

    assign mem_req   = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rx_clear  = rx_clear_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
